// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: fetch-stage PC generator with a single-outstanding
// instruction-bus handshake and a valid/ready output toward decode.
// Redirects from later stages override sequential flow in every state.
// Responses that belong to a request issued before a redirect are dropped.
// Optional feature macro: FETCH_MISALIGN_CHECK_EN. When it is defined,
// misaligned redirect targets bypass memory and are presented as a NOP
// flagged on out_misalign.
module fetch_pc_unit #(
  parameter int          XLEN      = 64,
  parameter logic [63:0] RESET_PC  = 64'h8000_0000,
  parameter int          NUM_REDIR = 2,
  parameter int          PC_STEP   = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REDIR-1:0]      redir_valid,
  input  logic [NUM_REDIR*XLEN-1:0] redir_pc,
  input  logic                      stall,
  output logic                      ireq_valid,
  output logic [XLEN-1:0]           ireq_addr,
  input  logic                      ireq_ready,
  input  logic                      iresp_valid,
  input  logic [31:0]               iresp_data,
  output logic                      out_valid,
  output logic [XLEN-1:0]           out_pc,
  output logic [31:0]               out_inst,
  input  logic                      out_ready,
  output logic                      busy
`ifdef FETCH_MISALIGN_CHECK_EN
  ,
  output logic                      out_misalign
`endif
);

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  state_t            state_r;
  logic [XLEN-1:0]   pc_r;
  logic [XLEN-1:0]   req_pc_r;
  logic              drop_r;
  logic              redir_any_s;
  logic [XLEN-1:0]   redir_tgt_s;
  logic              redir_mis_s;
  logic              req_xfer_s;

  // Redirect select: walk from the lowest-priority source up so index 0 wins.
  always_comb begin
    redir_tgt_s = '0;
    for (int i = NUM_REDIR - 1; i >= 0; i--) begin
      redir_tgt_s = redir_valid[i] ? redir_pc[i*XLEN +: XLEN] : redir_tgt_s;
    end
  end

  assign redir_any_s = |redir_valid;
  assign req_xfer_s  = ireq_valid && ireq_ready;
  assign ireq_addr   = pc_r;

`ifdef FETCH_MISALIGN_CHECK_EN
  assign redir_mis_s = (redir_tgt_s[1:0] != 2'b00);
`else
  assign redir_mis_s = 1'b0;
`endif

  // Fetch FSM: PC, outstanding-request tracking and all registered outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r    <= ST_REQ;
      pc_r       <= XLEN'(RESET_PC);
      req_pc_r   <= '0;
      drop_r     <= 1'b0;
      out_valid  <= 1'b0;
      out_pc     <= '0;
      out_inst   <= 32'h0000_0000;
      ireq_valid <= 1'b0;
      busy       <= 1'b0;
    end else begin
      case (state_r)
        ST_REQ: begin
          if (redir_any_s) begin
            pc_r <= redir_tgt_s;
            if (redir_mis_s) begin
              // Misaligned target: present a NOP directly, no bus request.
              state_r    <= ST_HOLD;
              out_valid  <= 1'b1;
              out_pc     <= redir_tgt_s;
              out_inst   <= NOP_INST;
              ireq_valid <= 1'b0;
              busy       <= 1'b0;
            end else if (req_xfer_s) begin
              // The address accepted this cycle is already stale.
              state_r    <= ST_WAIT;
              drop_r     <= 1'b1;
              ireq_valid <= 1'b0;
              busy       <= 1'b1;
            end else begin
              state_r    <= ST_REQ;
              ireq_valid <= 1'b1;
              busy       <= 1'b0;
            end
          end else if (req_xfer_s) begin
            state_r    <= ST_WAIT;
            drop_r     <= 1'b0;
            req_pc_r   <= pc_r;
            ireq_valid <= 1'b0;
            busy       <= 1'b1;
          end else begin
            // Also raises ireq_valid on the first cycle out of reset.
            state_r    <= ST_REQ;
            ireq_valid <= 1'b1;
            busy       <= 1'b0;
          end
        end

        ST_WAIT: begin
          if (redir_any_s) begin
            pc_r <= redir_tgt_s;
            if (redir_mis_s) begin
              state_r    <= ST_HOLD;
              drop_r     <= 1'b0;
              out_valid  <= 1'b1;
              out_pc     <= redir_tgt_s;
              out_inst   <= NOP_INST;
              ireq_valid <= 1'b0;
              busy       <= 1'b0;
            end else if (iresp_valid) begin
              // Response of the old stream lands now: discard and refetch.
              state_r    <= ST_REQ;
              drop_r     <= 1'b1;
              ireq_valid <= 1'b1;
              busy       <= 1'b0;
            end else begin
              // Keep waiting for the old response, then throw it away.
              state_r    <= ST_WAIT;
              drop_r     <= 1'b1;
              ireq_valid <= 1'b0;
              busy       <= 1'b1;
            end
          end else if (iresp_valid && drop_r) begin
            state_r    <= ST_REQ;
            drop_r     <= 1'b0;
            ireq_valid <= 1'b1;
            busy       <= 1'b0;
          end else if (iresp_valid) begin
            state_r    <= ST_HOLD;
            out_valid  <= 1'b1;
            out_pc     <= req_pc_r;
            out_inst   <= iresp_data;
            ireq_valid <= 1'b0;
            busy       <= 1'b0;
          end else begin
            state_r    <= ST_WAIT;
            ireq_valid <= 1'b0;
            busy       <= 1'b1;
          end
        end

        ST_HOLD: begin
          if (redir_any_s) begin
            pc_r <= redir_tgt_s;
            if (redir_mis_s) begin
              state_r    <= ST_HOLD;
              out_valid  <= 1'b1;
              out_pc     <= redir_tgt_s;
              out_inst   <= NOP_INST;
              ireq_valid <= 1'b0;
              busy       <= 1'b0;
            end else begin
              state_r    <= ST_REQ;
              out_valid  <= 1'b0;
              ireq_valid <= 1'b1;
              busy       <= 1'b0;
            end
          end else if (out_ready && !stall) begin
            state_r    <= ST_REQ;
            out_valid  <= 1'b0;
            pc_r       <= pc_r + XLEN'(PC_STEP);
            ireq_valid <= 1'b1;
            busy       <= 1'b0;
          end else begin
            state_r    <= ST_HOLD;
            ireq_valid <= 1'b0;
            busy       <= 1'b0;
          end
        end

        default: begin
          state_r    <= ST_REQ;
          drop_r     <= 1'b0;
          out_valid  <= 1'b0;
          ireq_valid <= 1'b1;
          busy       <= 1'b0;
        end
      endcase
    end
  end

`ifdef FETCH_MISALIGN_CHECK_EN
  // Misalign flag: set by a misaligned redirect, cleared by any other load.
  always_ff @(posedge clk) begin
    if (!reset) begin
      out_misalign <= 1'b0;
    end else if (redir_any_s) begin
      out_misalign <= redir_mis_s;
    end else if ((state_r == ST_WAIT) && iresp_valid) begin
      out_misalign <= 1'b0;
    end else begin
      out_misalign <= out_misalign;
    end
  end
`endif

endmodule

// File: doc/fetch_pc_unit.md
Name: fetch_pc_unit

Overview:
- Parametrised fetch-stage PC generator with a built-in instruction-bus handshake.
- Holds the architectural fetch PC and issues one instruction request at a time.
- Tracks the outstanding request and drops stale responses after a redirect.
- Presents fetched {pc, inst} to decode through a valid/ready interface. Prioritised redirect sources from later stages override sequential flow at any point.

Parameters:
- XLEN, 64, PC/address width.
- RESET_PC, 64'h8000_0000, PC loaded on reset, truncated to XLEN.
- NUM_REDIR, 2, number of redirect sources; index 0 has highest priority.
- PC_STEP, 4, sequential increment in bytes.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous reset, active-low (reset==0 resets on the clk rising edge).
- redir_valid  in  NUM_REDIR  per-source redirect request.
- redir_pc  in  NUM_REDIR*XLEN  targets; source i occupies bits [i*XLEN +: XLEN].
- stall  in  1  downstream hazard stall; blocks consumption of the held instruction.
- ireq_valid  out  1  instruction request valid.
- ireq_addr  out  XLEN  request address.
- ireq_ready  in  1  memory accepts the request (transfer = ireq_valid && ireq_ready).
- iresp_valid  in  1  response valid; one response per accepted request, in order.
- iresp_data  in  32  instruction word.
- out_valid  out  1  fetched instruction valid.
- out_pc  out  XLEN  PC of the fetched instruction.
- out_inst  out  32  instruction word.
- out_ready  in  1  decode accepts.
- busy  out  1  a request has been accepted and its response is not yet received.

Behaviour:
- Reset (reset==0): pc=RESET_PC, state=REQ, drop=0, out_valid=0, out_pc=0, out_inst=0. ireq_valid is 0 during reset and 1 on the first cycle after reset. busy=0.
- Redirect select:
  - Lowest asserted index wins; the target is its redir_pc slice.
  - redir_any = |redir_valid.
  - Redirect overrides stall and all handshakes.
- State REQ:
  - Outputs: ireq_valid=1, ireq_addr=pc.
  - ireq_addr may change before acceptance; memory samples only on transfer.
  - If redir_any: pc<=target. If ireq_ready is also high, go to WAIT with drop<=1 (the in-flight address is stale); otherwise stay in REQ.
  - Else if ireq_ready: go to WAIT, drop<=0, req_pc<=pc.
- State WAIT:
  - Outputs: ireq_valid=0, busy=1.
  - If redir_any: pc<=target, drop<=1. An iresp_valid in the same cycle is discarded and the state goes to REQ.
  - Else if iresp_valid and drop=1: discard the response, drop<=0, go to REQ.
  - Else if iresp_valid and drop=0: out_pc<=req_pc, out_inst<=iresp_data, out_valid<=1, go to HOLD.
- State HOLD:
  - Outputs: out_valid=1; out_pc/out_inst stable.
  - If redir_any: out_valid<=0, pc<=target, go to REQ. If out_ready was high in the same cycle, the transfer still counts; the flushing stage owns the squash.
  - Else if out_ready && !stall: out_valid<=0, pc<=pc+PC_STEP, go to REQ.
  - Else: hold all outputs.
- Timing:
  - Minimum fetch-to-fetch period is 3 cycles (REQ→WAIT→HOLD→REQ) with zero-wait memory.
  - Redirect-to-request latency: ireq_addr=target on the cycle after redirect.
- Arithmetic: pc+PC_STEP wraps modulo 2^XLEN, with no overflow flag.
- iresp_valid outside WAIT is ignored.
- The memory side shares this reset, so no pre-reset response can arrive after reset.
- Reset mid-operation: any state returns to REQ immediately. The outstanding request is forgotten and drop is cleared.

Optional Feature:
- Macro: FETCH_MISALIGN_CHECK_EN.
- Enabled:
  - Adds port out_misalign (out, 1).
  - A redirect target with target[1:0]!=0 issues no request. After the redirect cycle, the unit goes directly to HOLD with out_pc=target, out_inst=32'h0000_0013 and out_misalign=1.
  - Consumption or a further redirect proceeds as normal HOLD.
  - out_misalign=0 for all other instructions and on reset.
- Disabled: port absent; low target bits pass through to ireq_addr unchecked.

Test Plan:
- Release reset with zero-wait memory and out_ready=1, stall=0 → ireq_addr sequence 0x8000_0000, 0x8000_0004, 0x8000_0008, each 3 cycles apart; out_pc matches.
- In HOLD with out_ready=1, stall=1 for 5 cycles → out_valid, out_pc and out_inst stable for all 5 cycles; pc advances by 4 only after stall drops.
- In WAIT at 0x8000_0010, redir_valid=2'b01 with target 0x8000_0100; the response arrives 2 cycles later → response discarded, out_valid stays 0, next ireq_addr=0x8000_0100.
- Same-cycle redir_valid=2'b11 with targets 0x100 (src0) and 0x200 (src1) → next ireq_addr=0x100.
- Set pc to 0xFFFF_FFFF_FFFF_FFFC via redirect, then consume → next ireq_addr=0x0.
- Drive reset=0 in WAIT, then release → ireq_valid=1 with ireq_addr=0x8000_0000 and busy=0. With FETCH_MISALIGN_CHECK_EN, redirect to 0x8000_0002 → no ireq; out_misalign=1, out_inst=0x13, out_pc=0x8000_0002.
